arbiter_mux: RTL and testbench

ARBITER_MUX -- requirements
Module: arbiter_mux

---
 rtl/arbiter_mux_pkg.sv | 14 +
 rtl/arbiter_mux_rr_priority_picker.sv | 38 +++
 rtl/arbiter_mux.sv | 124 ++++++++++++
 tb/tb_arbiter_mux.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arbiter_mux_pkg.sv
// Shared types and helpers for the arbiter_mux block.
package arbiter_mux_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } arb_state_e;

    // Index width for n items; never below one bit so single-channel builds stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbiter_mux_rr_priority_picker.sv
// Combinational winner selection: round-robin after last_owner_i, or lowest index in fixed mode.
module rr_priority_picker
    import arbiter_mux_pkg::*;
#(
    parameter int unsigned INPUTS = 4,
    parameter int unsigned IW     = idx_width(INPUTS)
) (
    input  logic [INPUTS-1:0] request_i,
    input  logic [IW-1:0]     last_owner_i,
    input  logic [INPUTS-1:0] mask_i,
    input  logic              fixed_i,
    output logic [INPUTS-1:0] winner_o
);

    logic [INPUTS-1:0] eligible;
    logic              found;

    // First pass takes the lowest eligible index above last_owner_i; the second pass
    // is the wrap-around (and the whole search in fixed mode).
    always_comb begin
        eligible = request_i & ~mask_i;
        winner_o = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            if (!fixed_i && !found && eligible[i] && (IW'(i) > last_owner_i)) begin
                winner_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
        for (int unsigned i = 0; i < INPUTS; i++) begin
            if (!found && eligible[i]) begin
                winner_o[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_mux.sv
// Arbitrated N:1 data mux with registered one-hot grant and optional hold-limit handoff.
module arbiter_mux
    import arbiter_mux_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned INPUTS         = 4,
    parameter int unsigned FIXED_PRIORITY = 0,
    parameter int unsigned HOLD_LIMIT     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUTS-1:0]       request,
    input  logic [WIDTH*INPUTS-1:0] in,
    output logic [INPUTS-1:0]       grant,
    output logic [WIDTH-1:0]        out,
    output logic                    outputEnable,
    output logic                    preempted
);

    localparam int unsigned IW = idx_width(INPUTS);
    localparam int unsigned CW = idx_width(HOLD_LIMIT + 1);
    localparam logic [CW-1:0] CNT_SAT = (HOLD_LIMIT == 0) ? '1 : CW'(HOLD_LIMIT);
    localparam bit PREEMPT_EN = (HOLD_LIMIT != 0) && (INPUTS > 1);

    arb_state_e        state_q, state_d;
    logic [INPUTS-1:0] grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              preempted_q, preempted_d;

    logic [INPUTS-1:0] winner;
    logic [IW-1:0]     winner_idx;
    logic              others_req;
    logic              owner_req;
    logic              hold_due;

    // Masking the current owner makes the picker usable for both drop and handoff cases.
    rr_priority_picker #(
        .INPUTS (INPUTS),
        .IW     (IW)
    ) u_picker (
        .request_i    (request),
        .last_owner_i (last_q),
        .mask_i       (grant_q),
        .fixed_i      (FIXED_PRIORITY != 0),
        .winner_o     (winner)
    );

    always_comb begin
        winner_idx = '0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            if (winner[i]) winner_idx = IW'(i);
        end
    end

    assign others_req = |winner;
    assign owner_req  = |(request & grant_q);
    assign hold_due   = PREEMPT_EN && (cnt_q == CNT_SAT) && others_req;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        preempted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (others_req) begin
                    grant_d = winner;
                    last_d  = winner_idx;
                    cnt_d   = CW'(1);
                    state_d = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (owner_req && !hold_due) begin
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
                end else if (others_req) begin
                    grant_d     = winner;
                    last_d      = winner_idx;
                    cnt_d       = CW'(1);
                    preempted_d = owner_req;
                end else begin
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_q      <= IW'(INPUTS - 1);
            cnt_q       <= '0;
            preempted_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            preempted_q <= preempted_d;
        end
    end

    always_comb begin
        out = '0;
        for (int unsigned i = 0; i < INPUTS; i++) begin
            out = out | (in[i*WIDTH +: WIDTH] & {WIDTH{grant_q[i]}});
        end
    end

    assign grant        = grant_q;
    assign outputEnable = |grant_q;
    assign preempted    = preempted_q;

endmodule

// File: tb/tb_arbiter_mux.sv
// Directed and randomized checks of arbiter_mux in round-robin, fixed-priority and hold-limit builds.
module tb_arbiter_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_rr, req_fx, req_hl;
    logic [31:0] in_bus;
    logic [3:0]  g_rr, g_fx, g_hl;
    logic [7:0]  out_rr, out_fx, out_hl;
    logic        oe_rr, oe_fx, oe_hl;
    logic        pre_rr, pre_fx, pre_hl;

    int checks = 0;
    int errors = 0;
    int waits [4];

    logic [3:0] HL_G [10] = '{4'h1, 4'h1, 4'h1, 4'h8, 4'h8, 4'h8, 4'h1, 4'h1, 4'h1, 4'h8};
    logic       HL_P [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    arbiter_mux #(.WIDTH(8), .INPUTS(4), .FIXED_PRIORITY(0), .HOLD_LIMIT(0)) u_rr (
        .clk(clk), .rst(rst), .request(req_rr), .in(in_bus),
        .grant(g_rr), .out(out_rr), .outputEnable(oe_rr), .preempted(pre_rr)
    );

    arbiter_mux #(.WIDTH(8), .INPUTS(4), .FIXED_PRIORITY(1), .HOLD_LIMIT(0)) u_fx (
        .clk(clk), .rst(rst), .request(req_fx), .in(in_bus),
        .grant(g_fx), .out(out_fx), .outputEnable(oe_fx), .preempted(pre_fx)
    );

    arbiter_mux #(.WIDTH(8), .INPUTS(4), .FIXED_PRIORITY(0), .HOLD_LIMIT(3)) u_hl (
        .clk(clk), .rst(rst), .request(req_hl), .in(in_bus),
        .grant(g_hl), .out(out_hl), .outputEnable(oe_hl), .preempted(pre_hl)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reset_pulse();
        req_rr = '0;
        req_fx = '0;
        req_hl = '0;
        rst    = 1'b1;
        step();
        rst    = 1'b0;
    endtask

    initial begin
        logic [3:0] cur, nxt;

        rst    = 1'b1;
        req_rr = '0;
        req_fx = '0;
        req_hl = '0;
        in_bus = 32'h4433A511;
        step();
        step();
        check("rst_g_rr", g_rr, 4'h0);
        check("rst_g_fx", g_fx, 4'h0);
        check("rst_g_hl", g_hl, 4'h0);
        check("rst_out", {out_rr, out_fx, out_hl}, 24'h0);
        check("rst_oe", {oe_rr, oe_fx, oe_hl}, 3'b000);
        check("rst_pre", {pre_rr, pre_fx, pre_hl}, 3'b000);

        // First arbitration after release: lastOwner=3 so ch1 is first requester found.
        rst    = 1'b0;
        req_rr = 4'b0110;
        step();
        check("first_grant", g_rr, 4'b0010);
        check("first_out", out_rr, 8'hA5);
        check("first_oe", oe_rr, 1'b1);
        in_bus[15:8] = 8'h5A;
        #1;
        check("comb_out", out_rr, 8'h5A);
        in_bus = 32'h4433A511;
        req_rr = 4'b0000;
        step();
        check("drop_idle_g", g_rr, 4'h0);
        check("drop_idle_out", out_rr, 8'h00);
        check("drop_idle_oe", oe_rr, 1'b0);

        reset_pulse();
        req_rr = 4'b1111;
        step();
        check("rr_g0", g_rr, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            cur = 4'b0001 << k;
            nxt = (k == 3) ? 4'b0001 : (cur << 1);
            req_rr = 4'b1111;
            step();
            check("rr_hold", g_rr, cur);
            req_rr = 4'b1111 & ~cur;
            step();
            check("rr_next", g_rr, nxt);
        end

        reset_pulse();
        req_fx = 4'b0100;
        step();
        check("fx_own2", g_fx, 4'b0100);
        req_fx = 4'b0101;
        step();
        check("fx_keep_a", g_fx, 4'b0100);
        step();
        check("fx_keep_b", g_fx, 4'b0100);
        req_fx = 4'b0001;
        step();
        check("fx_to0", g_fx, 4'b0001);
        req_fx = 4'b1010;
        step();
        check("fx_lowest", g_fx, 4'b0010);

        reset_pulse();
        req_hl = 4'b1001;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hl_grant", g_hl, HL_G[k]);
            check("hl_pre", pre_hl, HL_P[k]);
        end
        check("hl_out", out_hl, 8'h44);
        req_hl = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            step();
            check("hl_alone_g", g_hl, 4'b1000);
            check("hl_alone_pre", pre_hl, 1'b0);
        end
        req_hl = 4'b0000;
        step();
        check("hl_idle", g_hl, 4'h0);

        reset_pulse();
        req_rr = 4'b0100;
        step();
        check("mid_own", g_rr, 4'b0100);
        check("mid_out", out_rr, 8'h33);
        rst = 1'b1;
        step();
        check("mid_rst_g", g_rr, 4'h0);
        check("mid_rst_out", out_rr, 8'h00);
        check("mid_rst_oe", oe_rr, 1'b0);
        rst = 1'b0;
        step();
        check("post_rst_g", g_rr, 4'b0100);

        reset_pulse();
        for (int c = 0; c < 4; c++) waits[c] = 0;
        for (int n = 0; n < 10000; n++) begin
            in_bus = $urandom;
            for (int c = 0; c < 4; c++) begin
                if (req_rr[c] && !g_rr[c]) req_rr[c] = 1'b1;
                else req_rr[c] = 1'($urandom_range(0, 1));
                if (req_fx[c] && !g_fx[c]) req_fx[c] = ($urandom_range(0, 3) != 0);
                else req_fx[c] = 1'($urandom_range(0, 1));
                if (req_hl[c] && !g_hl[c]) req_hl[c] = 1'b1;
                else if (g_hl[c]) req_hl[c] = ($urandom_range(0, 4) != 0);
                else req_hl[c] = 1'($urandom_range(0, 1));
            end
            step();
            check("rand_onehot_rr", $onehot0(g_rr), 1'b1);
            check("rand_onehot_fx", $onehot0(g_fx), 1'b1);
            check("rand_onehot_hl", $onehot0(g_hl), 1'b1);
            for (int c = 0; c < 4; c++) begin
                if (g_hl[c]) begin
                    waits[c] = 0;
                end else if (req_hl[c]) begin
                    waits[c]++;
                    check("rand_wait_hl", (waits[c] <= 9), 1'b1);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
